// File: rtl/cluster_speriph_plug_arb.sv
// -----------------------------------------------------------------------------
// cluster_speriph_plug_arb
//
// Round-robin arbiter that lets NB_PLUGS peripheral plugs share one slave port
// (the event unit). A winner is picked each cycle, starting at rr_ptr. It is
// forwarded to the slave, and the slave grant is passed back to that plug in
// the same cycle. The index of every granted plug is queued in a small FIFO so
// that the in-order slave responses can be routed back to the plug that issued
// the request.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   s_req_i .. s_id_i    per-plug request bundle (address, wen, wdata, be, id)
//   s_gnt_o              per-plug grant (zero-cycle path from m_gnt_i)
//   s_r_valid_o          per-plug response valid
//   s_r_rdata_o/opc/id   shared response payload, passed through from m_r_*
//   m_req_o .. m_id_o    request to the slave, driven by the winner
//   m_gnt_i              slave grant
//   m_r_valid_i .. m_r_id_i  slave response
//   busy_o               at least one transaction outstanding (registered)
//   err_o                sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module cluster_speriph_plug_arb #(
  parameter int NB_PLUGS  = 2,
  parameter int ID_WIDTH  = 5,
  parameter int RSP_DEPTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,

  input  logic [NB_PLUGS-1:0]                s_req_i,
  input  logic [NB_PLUGS-1:0][31:0]          s_add_i,
  input  logic [NB_PLUGS-1:0]                s_wen_i,
  input  logic [NB_PLUGS-1:0][31:0]          s_wdata_i,
  input  logic [NB_PLUGS-1:0][3:0]           s_be_i,
  input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  s_id_i,
  output logic [NB_PLUGS-1:0]                s_gnt_o,
  output logic [NB_PLUGS-1:0]                s_r_valid_o,
  output logic [31:0]                        s_r_rdata_o,
  output logic                               s_r_opc_o,
  output logic [ID_WIDTH-1:0]                s_r_id_o,

  output logic                               m_req_o,
  output logic [31:0]                        m_add_o,
  output logic                               m_wen_o,
  output logic [31:0]                        m_wdata_o,
  output logic [3:0]                         m_be_o,
  output logic [ID_WIDTH-1:0]                m_id_o,
  input  logic                               m_gnt_i,
  input  logic                               m_r_valid_i,
  input  logic [31:0]                        m_r_rdata_i,
  input  logic                               m_r_opc_i,
  input  logic [ID_WIDTH-1:0]                m_r_id_i,

  output logic                               busy_o,
  output logic                               err_o
);

  localparam int PTR_W = $clog2(NB_PLUGS);
  // A depth of 1 still needs a one-bit pointer; it simply never leaves 0.
  localparam int AW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_DEPTH + 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;

  logic [PTR_W-1:0] fifo_mem [RSP_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;

  logic full;
  logic empty;
  logic handshake;
  logic pop;
  logic busy_q;
  logic err_q;

  // Explicit wrap so non-power-of-2 arithmetic never leaks into the pointers.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(RSP_DEPTH - 1)) return '0;
    else                         return p + 1'b1;
  endfunction

  assign full  = (count == CW'(RSP_DEPTH));
  assign empty = (count == '0);

  // Winner search: first requester at or after rr_ptr, wrapping around.
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top, otherwise paths that skip the assignment infer a latch.
  always_comb begin
    winner = rr_ptr;
    cand   = '0;
    for (int i = NB_PLUGS - 1; i >= 0; i--) begin
      // Walking downwards means the last hit (closest to rr_ptr) wins.
      cand = PTR_W'((int'(rr_ptr) + i) % NB_PLUGS);
      if (s_req_i[cand]) winner = cand;
    end
  end

  // A full FIFO blocks new requests even if a pop happens this cycle, so the
  // grant path never depends on the response path.
  assign m_req_o   = (|s_req_i) & ~full & ~rst_i;
  assign m_add_o   = s_add_i[winner];
  assign m_wen_o   = s_wen_i[winner];
  assign m_wdata_o = s_wdata_i[winner];
  assign m_be_o    = s_be_i[winner];
  assign m_id_o    = s_id_i[winner];

  assign handshake = m_req_o & m_gnt_i;
  // Responses with nothing outstanding are dropped (and flagged in err_q).
  assign pop       = m_r_valid_i & ~empty & ~rst_i;

  always_comb begin
    s_gnt_o         = '0;
    s_gnt_o[winner] = handshake;
  end

  always_comb begin
    s_r_valid_o = '0;
    if (pop) s_r_valid_o[fifo_mem[rd_ptr]] = 1'b1;
  end

  assign s_r_rdata_o = m_r_rdata_i;
  assign s_r_opc_o   = m_r_opc_i;
  assign s_r_id_o    = m_r_id_i;

  // handshake implies not full, so push+pop leaves the count unchanged.
  always_comb begin
    count_nxt = count;
    if (handshake && !pop)      count_nxt = count + 1'b1;
    else if (!handshake && pop) count_nxt = count - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      count  <= count_nxt;
      busy_q <= (count_nxt != '0);
      if (handshake) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rr_ptr <= (winner == PTR_W'(NB_PLUGS - 1)) ? '0 : winner + 1'b1;
      end
      if (pop)                  rd_ptr <= ptr_inc(rd_ptr);
      if (m_r_valid_i && empty) err_q  <= 1'b1;
    end
  end

  // NOTE: the routing storage has no reset; an entry is only ever read after
  // it has been written, and the count/pointers that guard it are reset.
  always_ff @(posedge clk_i) begin
    if (handshake) fifo_mem[wr_ptr] <= winner;
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_cluster_speriph_plug_arb.sv
// -----------------------------------------------------------------------------
// tb_cluster_speriph_plug_arb
//
// Directed bench for the two-plug, depth-2 configuration. Inputs are applied
// on the falling edge. Outputs are sampled 1 ns later, before the next rising
// edge. Registered outputs (busy_o, err_o) therefore show the state left by
// the previous rising edge.
// -----------------------------------------------------------------------------
module tb_cluster_speriph_plug_arb;

  localparam int NB_PLUGS  = 2;
  localparam int ID_WIDTH  = 5;
  localparam int RSP_DEPTH = 2;

  logic                              clk_i = 1'b0;
  logic                              rst_i;
  logic [NB_PLUGS-1:0]               s_req_i;
  logic [NB_PLUGS-1:0][31:0]         s_add_i;
  logic [NB_PLUGS-1:0]               s_wen_i;
  logic [NB_PLUGS-1:0][31:0]         s_wdata_i;
  logic [NB_PLUGS-1:0][3:0]          s_be_i;
  logic [NB_PLUGS-1:0][ID_WIDTH-1:0] s_id_i;
  logic [NB_PLUGS-1:0]               s_gnt_o;
  logic [NB_PLUGS-1:0]               s_r_valid_o;
  logic [31:0]                       s_r_rdata_o;
  logic                              s_r_opc_o;
  logic [ID_WIDTH-1:0]               s_r_id_o;
  logic                              m_req_o;
  logic [31:0]                       m_add_o;
  logic                              m_wen_o;
  logic [31:0]                       m_wdata_o;
  logic [3:0]                        m_be_o;
  logic [ID_WIDTH-1:0]               m_id_o;
  logic                              m_gnt_i;
  logic                              m_r_valid_i;
  logic [31:0]                       m_r_rdata_i;
  logic                              m_r_opc_i;
  logic [ID_WIDTH-1:0]               m_r_id_i;
  logic                              busy_o;
  logic                              err_o;

  int n_vec = 0;
  int n_err = 0;

  cluster_speriph_plug_arb #(
    .NB_PLUGS (NB_PLUGS),
    .ID_WIDTH (ID_WIDTH),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_req_i    (s_req_i),
    .s_add_i    (s_add_i),
    .s_wen_i    (s_wen_i),
    .s_wdata_i  (s_wdata_i),
    .s_be_i     (s_be_i),
    .s_id_i     (s_id_i),
    .s_gnt_o    (s_gnt_o),
    .s_r_valid_o(s_r_valid_o),
    .s_r_rdata_o(s_r_rdata_o),
    .s_r_opc_o  (s_r_opc_o),
    .s_r_id_o   (s_r_id_o),
    .m_req_o    (m_req_o),
    .m_add_o    (m_add_o),
    .m_wen_o    (m_wen_o),
    .m_wdata_o  (m_wdata_o),
    .m_be_o     (m_be_o),
    .m_id_o     (m_id_o),
    .m_gnt_i    (m_gnt_i),
    .m_r_valid_i(m_r_valid_i),
    .m_r_rdata_i(m_r_rdata_i),
    .m_r_opc_i  (m_r_opc_i),
    .m_r_id_i   (m_r_id_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then wait until the outputs have settled.
  task automatic step(input logic rst, input logic [1:0] req, input logic gnt,
                      input logic rv, input logic [4:0] rid);
    @(negedge clk_i);
    rst_i       = rst;
    s_req_i     = req;
    m_gnt_i     = gnt;
    m_r_valid_i = rv;
    m_r_id_i    = rid;
    #1;
  endtask

  // Shorthand for the handshake/response outputs checked nearly every cycle.
  task automatic expect_gv(input string tag, input logic [1:0] gnt, input logic [1:0] rv);
    check({tag, ".gnt"},    32'(s_gnt_o),     32'(gnt));
    check({tag, ".rvalid"}, 32'(s_r_valid_o), 32'(rv));
  endtask

  initial begin
    rst_i       = 1'b1;
    s_req_i     = '0;
    m_gnt_i     = 1'b0;
    m_r_valid_i = 1'b0;
    m_r_id_i    = '0;
    m_r_rdata_i = 32'hCAFE_F00D;
    m_r_opc_i   = 1'b1;
    s_add_i[0]   = 32'h0000_0100; s_add_i[1]   = 32'h0000_0200;
    s_wen_i[0]   = 1'b1;          s_wen_i[1]   = 1'b0;
    s_wdata_i[0] = 32'hAAAA_0000; s_wdata_i[1] = 32'h5555_1111;
    s_be_i[0]    = 4'hF;          s_be_i[1]    = 4'h3;
    s_id_i[0]    = 5'd3;          s_id_i[1]    = 5'd5;

    // Reset: everything forced low, even with requests and a response present.
    step(1'b1, 2'b11, 1'b1, 1'b1, 5'd0);
    check("rst.m_req", 32'(m_req_o), 32'd0);
    expect_gv("rst", 2'b00, 2'b00);
    step(1'b1, 2'b00, 1'b0, 1'b0, 5'd0);

    // Alternating grants with one-cycle responses.
    step(1'b0, 2'b11, 1'b1, 1'b0, 5'd0);
    check("rr.c1.busy", 32'(busy_o), 32'd0);
    check("rr.c1.err",  32'(err_o),  32'd0);
    expect_gv("rr.c1", 2'b01, 2'b00);
    check("rr.c1.add", m_add_o, 32'h0000_0100);
    check("rr.c1.id",  32'(m_id_o), 32'd3);
    step(1'b0, 2'b11, 1'b1, 1'b1, 5'd3);
    expect_gv("rr.c2", 2'b10, 2'b01);
    check("rr.c2.rid",   32'(s_r_id_o), 32'd3);
    check("rr.c2.rdata", s_r_rdata_o, 32'hCAFE_F00D);
    check("rr.c2.opc",   32'(s_r_opc_o), 32'd1);
    step(1'b0, 2'b11, 1'b1, 1'b1, 5'd5);
    expect_gv("rr.c3", 2'b01, 2'b10);
    check("rr.c3.busy", 32'(busy_o), 32'd1);
    step(1'b0, 2'b00, 1'b1, 1'b1, 5'd3);
    check("rr.c4.m_req", 32'(m_req_o), 32'd0);
    expect_gv("rr.c4", 2'b00, 2'b01);

    // Plug 1 alone, then plug 0 joins (rr_ptr is 1 here, becomes 0).
    step(1'b0, 2'b10, 1'b1, 1'b0, 5'd0);
    check("solo.busy", 32'(busy_o), 32'd0);
    expect_gv("solo", 2'b10, 2'b00);
    check("solo.add",   m_add_o,   32'h0000_0200);
    check("solo.id",    32'(m_id_o), 32'd5);
    check("solo.wen",   32'(m_wen_o), 32'd0);
    check("solo.wdata", m_wdata_o, 32'h5555_1111);
    check("solo.be",    32'(m_be_o), 32'h3);
    step(1'b0, 2'b11, 1'b1, 1'b1, 5'd5);
    expect_gv("join", 2'b01, 2'b10);
    check("join.rid", 32'(s_r_id_o), 32'd5);
    check("join.wen", 32'(m_wen_o), 32'd1);
    step(1'b0, 2'b00, 1'b0, 1'b1, 5'd3);
    expect_gv("join.rsp", 2'b00, 2'b01);

    // Stall: rr_ptr is brought back to 0, then the slave withholds its grant.
    step(1'b0, 2'b10, 1'b1, 1'b0, 5'd0);
    expect_gv("pre", 2'b10, 2'b00);
    step(1'b0, 2'b00, 1'b0, 1'b1, 5'd5);
    expect_gv("pre.rsp", 2'b00, 2'b10);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 2'b11, 1'b0, 1'b0, 5'd0);
      check("stall.m_req", 32'(m_req_o), 32'd1);
      check("stall.gnt",   32'(s_gnt_o), 32'd0);
      check("stall.add",   m_add_o, 32'h0000_0100);
    end
    check("stall.busy", 32'(busy_o), 32'd0);
    step(1'b0, 2'b11, 1'b1, 1'b0, 5'd0);
    expect_gv("unstall", 2'b01, 2'b00);

    // Fill the FIFO: 0 is outstanding, plug 1 fills the second slot.
    step(1'b0, 2'b11, 1'b1, 1'b0, 5'd0);
    expect_gv("fill", 2'b10, 2'b00);
    step(1'b0, 2'b11, 1'b1, 1'b0, 5'd0);
    check("full.m_req", 32'(m_req_o), 32'd0);
    check("full.gnt",   32'(s_gnt_o), 32'd0);
    check("full.busy",  32'(busy_o), 32'd1);
    step(1'b0, 2'b11, 1'b1, 1'b1, 5'd3);
    expect_gv("full.pop", 2'b00, 2'b01);
    step(1'b0, 2'b11, 1'b1, 1'b0, 5'd0);
    expect_gv("resume", 2'b01, 2'b00);
    step(1'b0, 2'b00, 1'b0, 1'b1, 5'd5);
    expect_gv("drain1", 2'b00, 2'b10);
    step(1'b0, 2'b00, 1'b0, 1'b1, 5'd3);
    expect_gv("drain2", 2'b00, 2'b01);
    step(1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    check("idle.busy", 32'(busy_o), 32'd0);
    check("idle.err",  32'(err_o),  32'd0);

    // Spurious response with an empty FIFO.
    step(1'b0, 2'b00, 1'b0, 1'b1, 5'd7);
    check("spur.rvalid", 32'(s_r_valid_o), 32'd0);
    check("spur.err0",   32'(err_o), 32'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    check("spur.err1", 32'(err_o), 32'd1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    check("spur.sticky", 32'(err_o), 32'd1);

    // Reset clears err_o and rr_ptr (it was 1 before this).
    step(1'b1, 2'b11, 1'b1, 1'b0, 5'd0);
    check("rst2.m_req", 32'(m_req_o), 32'd0);
    check("rst2.gnt",   32'(s_gnt_o), 32'd0);
    step(1'b0, 2'b11, 1'b1, 1'b0, 5'd0);
    check("rst2.err",  32'(err_o),  32'd0);
    check("rst2.busy", 32'(busy_o), 32'd0);
    expect_gv("rst2.rr", 2'b01, 2'b00);

    // Reset with one transaction outstanding; the stale response is an error.
    step(1'b1, 2'b00, 1'b0, 1'b1, 5'd3);
    check("midrst.rvalid", 32'(s_r_valid_o), 32'd0);
    check("midrst.busy1",  32'(busy_o), 32'd1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    check("midrst.busy0", 32'(busy_o), 32'd0);
    check("midrst.err0",  32'(err_o),  32'd0);
    step(1'b0, 2'b00, 1'b0, 1'b1, 5'd3);
    check("stale.rvalid", 32'(s_r_valid_o), 32'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
    check("stale.err", 32'(err_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
